lives_controller: RTL and testbench
===================================

LIVES_CONTROLLER -- requirements
Module: lives_controller

Interface
REQ-001 The block SHALL have parameter INIT_LIVES, default 3, the lives loaded at reset and on newGame (legal range 1..3).
REQ-002 The block SHALL have parameter INVULN_FRAMES, default 64, the frames of invulnerability after a non-fatal hit (legal range 1..255).
REQ-003 The block SHALL have parameter BLINK_SHIFT, default 3, the frame-counter bit that drives blinking (legal range 0..7).
REQ-004 The block SHALL have port clk, input, 1, system clock.
REQ-005 The block SHALL have port resetN, input, 1, reset, asynchronous, active-low.
REQ-006 The block SHALL have port startOfFrame, input, 1, one-clk pulse per video frame.
REQ-007 The block SHALL have port playerHit, input, 1, collision pulse between player and enemy bolt, sampled every clk.
REQ-008 The block SHALL have port newGame, input, 1, one-clk restart pulse.
REQ-009 The block SHALL have port extraLife, input, 1, one-clk bonus-life pulse.
REQ-010 The block SHALL have port lives, output, 2, remaining lives, feeding the lives-icon bitmap.
REQ-011 The block SHALL have port lifeLost, output, 1, one-clk pulse per accepted hit.
REQ-012 The block SHALL have port invulnerable, output, 1, high while hits are ignored.
REQ-013 The block SHALL have port playerVisible, output, 1, gates the player sprite drawing request.
REQ-014 The block SHALL have port gameOver, output, 1, high when no lives remain.

Function
REQ-015 The FSM SHALL have states ALIVE, INVULN and GAME_OVER, all registered outputs, and no combinational path from input to output.
REQ-016 In ALIVE, a playerHit with lives>1 SHALL, on the next clk: decrement lives; pulse lifeLost; load the frame counter with INVULN_FRAMES; go to INVULN.
REQ-017 In ALIVE, a playerHit with lives==1 SHALL, on the next clk: set lives=0; pulse lifeLost; set gameOver=1; go to GAME_OVER.
REQ-018 In INVULN, each startOfFrame SHALL decrement the frame counter; startOfFrame with counter==1 SHALL return to ALIVE with the counter at 0.
REQ-019 In INVULN and GAME_OVER, playerHit SHALL be ignored, with no lives change and no lifeLost.
REQ-020 invulnerable SHALL be 1 exactly while in INVULN.
REQ-021 playerVisible SHALL be 1 in ALIVE, 0 in GAME_OVER, and equal to counter bit BLINK_SHIFT in INVULN.
REQ-022 newGame in any state SHALL, next clk: set lives=INIT_LIVES; clear gameOver, invulnerable and the counter; go to ALIVE; newGame SHALL have priority over a simultaneous playerHit and extraLife.
REQ-023 A playerHit coincident with startOfFrame in ALIVE SHALL be processed as a hit, and the counter SHALL load INVULN_FRAMES without decrementing.
REQ-024 lives SHALL never wrap: no decrement below 0 and no increment above 3.
REQ-025 lifeLost SHALL be high for exactly one clk per accepted hit.

Reset
REQ-026 While resetN=0 the block SHALL hold: state ALIVE, lives=INIT_LIVES, lifeLost=0, invulnerable=0, playerVisible=1, gameOver=0, counter=0.
REQ-027 Reset asserted mid-INVULN SHALL abort invulnerability immediately, asynchronously.

Configuration
REQ-028 With EXTRA_LIFE_EN defined, extraLife in ALIVE or INVULN SHALL increment lives next clk, saturating at 3, without changing state or counter.
REQ-029 With EXTRA_LIFE_EN defined, extraLife in GAME_OVER SHALL be ignored, and extraLife coincident with an accepted hit SHALL be discarded (hit wins).
REQ-030 Without EXTRA_LIFE_EN, the extraLife port SHALL remain present and SHALL be ignored entirely.

Structure
REQ-031 Shared package lives_pkg SHALL hold: the FSM state enum typedef; MAX_LIVES=3; the default INVULN_FRAMES; the default BLINK_SHIFT.
REQ-032 The frame counter SHALL be a sub-module frame_countdown (8-bit load/decrement-on-pulse/zero flag); the FSM SHALL remain in lives_controller.

Verification
REQ-033 The bench SHALL cover: reset release, then playerHit -> lives 3->2, lifeLost one clk, invulnerable=1, playerVisible toggling every 8 frames.
REQ-034 The bench SHALL cover: hit at t, 10 more hits during INVULN -> lives stays 2; after 64 startOfFrame pulses invulnerable=0; next hit -> lives=1.
REQ-035 The bench SHALL cover: three separated hits -> lives 0, gameOver=1, playerVisible=0; a further hit -> no lifeLost.
REQ-036 The bench SHALL cover: GAME_OVER, newGame+playerHit same clk -> lives=3, ALIVE, gameOver=0, no lifeLost.
REQ-037 The bench SHALL cover, with EXTRA_LIFE_EN: lives=3 plus extraLife -> 3; lives=2 in INVULN plus extraLife -> 3, still invulnerable; without the macro lives stays unchanged.
REQ-038 The bench SHALL cover: resetN pulse low mid-INVULN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/lives_pkg.sv
// Shared definitions for the lives controller.
// Holds the FSM state encoding, the lives ceiling, the default
// invulnerability length and blink bit, and a saturating increment helper.
package lives_pkg;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam int MAX_LIVES          = 3;
  localparam int DEF_INVULN_FRAMES  = 64;
  localparam int DEF_BLINK_SHIFT    = 3;

  // Lives never go above MAX_LIVES.
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'(MAX_LIVES)) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// 8-bit frame countdown used to time the invulnerability window.
// Ports:
//   clk, resetN    clock, asynchronous active-low reset
//   clear          force count to 0 (highest priority)
//   load,load_val  load a new count (beats dec)
//   dec            decrement by one; holds at 0
//   count          current count
//   zero           count == 0
module frame_countdown (
  input  logic       clk,
  input  logic       resetN,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] count,
  output logic       zero
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                   count <= 8'd0;
    else if (clear)                count <= 8'd0;
    else if (load)                 count <= load_val;
    else if (dec && count != 8'd0) count <= count - 8'd1;
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/lives_controller.sv
// Player lives / invulnerability / game-over controller.
// A non-fatal hit costs a life and opens an invulnerability window of
// INVULN_FRAMES video frames during which the sprite blinks on counter
// bit BLINK_SHIFT. The last life lost enters GAME_OVER until newGame.
// Ports:
//   clk, resetN     clock, asynchronous active-low reset
//   startOfFrame    one-clk pulse per video frame
//   playerHit       collision pulse, sampled every clk
//   newGame         restart pulse (beats hit and extraLife)
//   extraLife       bonus-life pulse
//   lives           remaining lives (0..3)
//   lifeLost        one-clk pulse per accepted hit
//   invulnerable    high while in the invulnerability window
//   playerVisible   sprite draw enable (blinks while invulnerable)
//   gameOver        high when no lives remain
// Build option: define EXTRA_LIFE_EN to honour extraLife; otherwise the
// port is present but ignored.
module lives_controller
  import lives_pkg::*;
#(
  parameter int INIT_LIVES    = 3,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int BLINK_SHIFT   = DEF_BLINK_SHIFT
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       playerHit,
  input  logic       newGame,
  input  logic       extraLife,
  output logic [1:0] lives,
  output logic       lifeLost,
  output logic       invulnerable,
  output logic       playerVisible,
  output logic       gameOver
);

  state_t     state, state_n;
  logic [1:0] lives_q, lives_n;
  logic       lost_q, lost_n;
  logic       cnt_clear, cnt_load, cnt_dec, cnt_zero;
  logic [7:0] cnt;
  logic       extra_req, grant_extra;

`ifdef EXTRA_LIFE_EN
  assign extra_req = extraLife;
`else
  assign extra_req = 1'b0;
  logic unused_extra;
  assign unused_extra = extraLife;
`endif

  // Counter only runs down while invulnerable; in ALIVE it sits at 0, so a
  // hit coincident with startOfFrame just loads the full window.
  assign cnt_dec = startOfFrame && (state == INVULN);

  frame_countdown u_cnt (
    .clk      (clk),
    .resetN   (resetN),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (8'(INVULN_FRAMES)),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_n     = state;
    lives_n     = lives_q;
    lost_n      = 1'b0;
    cnt_clear   = 1'b0;
    cnt_load    = 1'b0;
    grant_extra = 1'b0;
    if (newGame) begin
      state_n   = ALIVE;
      lives_n   = 2'(INIT_LIVES);
      cnt_clear = 1'b1;
    end else begin
      case (state)
        ALIVE: begin
          if (playerHit) begin
            lost_n = 1'b1;
            if (lives_q <= 2'd1) begin
              lives_n = 2'd0;
              state_n = GAME_OVER;
            end else begin
              lives_n  = lives_q - 2'd1;
              state_n  = INVULN;
              cnt_load = 1'b1;
            end
          end else begin
            // A bonus arriving with an accepted hit is dropped.
            grant_extra = extra_req;
          end
        end
        INVULN: begin
          grant_extra = extra_req;
          // cnt_zero catches a window that somehow emptied without a frame
          // pulse so the FSM can never stick in INVULN.
          if ((cnt_dec && cnt == 8'd1) || cnt_zero) state_n = ALIVE;
        end
        GAME_OVER: ;
        default: state_n = ALIVE;
      endcase
      if (grant_extra) lives_n = sat_inc(lives_q);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= ALIVE;
      lives_q <= 2'(INIT_LIVES);
      lost_q  <= 1'b0;
    end else begin
      state   <= state_n;
      lives_q <= lives_n;
      lost_q  <= lost_n;
    end
  end

  // All outputs decode registered state only.
  assign lives        = lives_q;
  assign lifeLost     = lost_q;
  assign invulnerable = (state == INVULN);
  assign gameOver     = (state == GAME_OVER);

  always_comb begin
    case (state)
      INVULN:    playerVisible = cnt[BLINK_SHIFT];
      GAME_OVER: playerVisible = 1'b0;
      default:   playerVisible = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_lives_controller.sv
module tb_lives_controller;
  localparam int INIT = 3;
  localparam int FR   = 64;
  localparam int BS   = 3;

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, playerHit, newGame, extraLife;
  logic [1:0] lives;
  logic       lifeLost, invulnerable, playerVisible, gameOver;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: lives count, frames of protection left, game-over flag.
  int m_lives, m_inv;
  bit m_over, m_lost;

  always #5 clk = ~clk;

  lives_controller #(.INIT_LIVES(INIT), .INVULN_FRAMES(FR), .BLINK_SHIFT(BS)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playerHit(playerHit),
    .newGame(newGame), .extraLife(extraLife), .lives(lives), .lifeLost(lifeLost),
    .invulnerable(invulnerable), .playerVisible(playerVisible), .gameOver(gameOver)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lives = INIT; m_inv = 0; m_over = 0; m_lost = 0;
  endtask

  task automatic model_step(input bit h, input bit s, input bit n, input bit e);
    m_lost = 0;
    if (n) begin
      m_lives = INIT; m_inv = 0; m_over = 0;
    end else if (m_over) begin
    end else if (m_inv > 0) begin
      if (s) m_inv--;
`ifdef EXTRA_LIFE_EN
      if (e && m_lives < 3) m_lives++;
`endif
    end else if (h) begin
      m_lost = 1;
      m_lives--;
      if (m_lives == 0) m_over = 1;
      else m_inv = FR;
    end else begin
`ifdef EXTRA_LIFE_EN
      if (e && m_lives < 3) m_lives++;
`endif
    end
  endtask

  task automatic check_all(input string tag);
    int vis;
    vis = m_over ? 0 : (m_inv > 0) ? ((m_inv >> BS) & 1) : 1;
    chk({tag, ".lives"},    8'(lives),         8'(m_lives));
    chk({tag, ".lifeLost"}, 8'(lifeLost),      8'(m_lost));
    chk({tag, ".invuln"},   8'(invulnerable),  8'(m_inv > 0));
    chk({tag, ".visible"},  8'(playerVisible), 8'(vis));
    chk({tag, ".gameOver"}, 8'(gameOver),      8'(m_over));
  endtask

  task automatic cyc(input string tag, input bit h, input bit s, input bit n, input bit e);
    playerHit = h; startOfFrame = s; newGame = n; extraLife = e;
    @(posedge clk);
    model_step(h, s, n, e);
    #1;
    playerHit = 0; startOfFrame = 0; newGame = 0; extraLife = 0;
    check_all(tag);
  endtask

  initial begin
    resetN = 0; startOfFrame = 0; playerHit = 0; newGame = 0; extraLife = 0;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk); #1;
    resetN = 1;
    cyc("idle", 0, 0, 0, 0);

    // First hit, then hits ignored during the window, frames run it out.
    cyc("hit1", 1, 0, 0, 0);
    chk("hit1.lives_2", 8'(lives), 8'd2);
    cyc("hit1.after", 0, 0, 0, 0);
    chk("lifeLost_one_clk", 8'(lifeLost), 8'd0);
    for (int i = 0; i < 10; i++) cyc("inv_hit", 1, 0, 0, 0);
    chk("inv_hits.lives_2", 8'(lives), 8'd2);
    for (int i = 0; i < FR; i++) begin
      cyc("blink", 0, 1, 0, 0);
      cyc("blink_gap", 0, 0, 0, 0);
    end
    chk("window_closed", 8'(invulnerable), 8'd0);
    cyc("hit2", 1, 0, 0, 0);
    chk("hit2.lives_1", 8'(lives), 8'd1);
    for (int i = 0; i < FR; i++) cyc("drain", 0, 1, 0, 0);
    cyc("hit3", 1, 0, 0, 0);
    chk("hit3.gameOver", 8'(gameOver), 8'd1);
    cyc("over_hit", 1, 0, 0, 0);
    chk("over_hit.no_lost", 8'(lifeLost), 8'd0);
    cyc("over_extra", 0, 0, 0, 1);

    // Restart beats a simultaneous hit.
    cyc("newgame_hit", 1, 0, 1, 1);
    chk("newgame.lives_3", 8'(lives), 8'd3);
    cyc("extra_at_3", 0, 0, 0, 1);
    chk("extra_at_3.sat", 8'(lives), 8'd3);

    // Hit coincident with a frame pulse loads the full window.
    cyc("hit_sof", 1, 1, 0, 0);
    cyc("inv_extra", 0, 0, 0, 1);
`ifdef EXTRA_LIFE_EN
    chk("inv_extra.lives", 8'(lives), 8'd3);
`else
    chk("inv_extra.lives", 8'(lives), 8'd2);
`endif
    for (int i = 0; i < 5; i++) cyc("pre_rst", 0, 1, 0, 0);

    // Asynchronous reset in the middle of the window.
    #2 resetN = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("rst_hold");
    resetN = 1;
    cyc("post_rst", 0, 0, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit h, s, n, e;
      h = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0);
      n = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 15) == 0);
      cyc("rand", h, s, n, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
